// File: rtl/imem_responder.sv
// Instruction memory responder: loadable word array serving fetch requests.
// Latency: response in RESP exactly WAIT_STATES+1 cycles after accept.
// Backpressure: req_ready low while waiting; back-to-back accepts from RESP.
module imem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_STATES = 2,
  parameter logic [31:0] NOP_WORD    = 32'h00000013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        read_enable_cpu,
  input  logic [31:0] pc_rom,
  input  logic        flush,
  input  logic        load_en,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data,
  output logic        req_ready,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic        addr_err,
  output logic        busy
);

  localparam int unsigned AW        = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  WS        = 4'(WAIT_STATES);
  localparam logic [29:0] DEPTH_LIM = 30'(DEPTH_WORDS);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  // A byte address is unusable if misaligned or beyond the array.
  function automatic logic addr_bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a[31:2] >= DEPTH_LIM);
  endfunction

  logic [31:0] mem_q [DEPTH_WORDS];

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q;
  logic        err_q;

  logic          accept;
  logic          load_rsp;
  logic [31:0]   rd_pc;
  logic          rd_err;
  logic [AW-1:0] rd_idx;
  logic          wr_ok;
  logic [AW-1:0] wr_idx;

  assign req_ready  = (state_q != S_WAIT);
  assign busy       = (state_q != S_IDLE);
  assign inst_valid = (state_q == S_RESP);
  assign addr_err   = err_q;
  assign inst       = inst_q;

  assign accept = read_enable_cpu && req_ready && !flush;

  // With zero wait states RESP is entered straight from the accept edge,
  // so the address is still on pc_rom rather than in pc_q.
  assign rd_pc  = (state_q == S_WAIT) ? pc_q : pc_rom;
  assign rd_err = addr_bad(rd_pc);
  assign rd_idx = rd_pc[AW+1:2];

  // Reset blocks loads even though it leaves the array contents alone.
  assign wr_ok  = load_en && !reset && !addr_bad(load_addr);
  assign wr_idx = load_addr[AW+1:2];

  // Next-state logic: accept from IDLE/RESP, count down in WAIT, flush wins.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    case (state_q)
      S_IDLE, S_RESP: begin
        if (accept) begin
          pc_d    = pc_rom;
          cnt_d   = WS;
          state_d = (WS != 4'd0) ? S_WAIT : S_RESP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = S_RESP;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (flush) begin
      state_d = S_IDLE;
    end
  end

  assign load_rsp = (state_d == S_RESP);

  // Control and response registers; the response is captured on RESP entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      pc_q    <= 32'd0;
      inst_q  <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      err_q   <= load_rsp && rd_err;
      if (load_rsp) begin
        inst_q <= rd_err ? NOP_WORD : mem_q[rd_idx];
      end
    end
  end

  // Program-load port; a same-edge read sees the pre-write word.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_q[wr_idx] <= load_data;
    end
  end

endmodule

// File: doc/imem_responder.md
IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256, number of 32-bit instruction words stored (power of two, 4..4096).
REQ-002 SHALL have parameter WAIT_STATES, default 2, extra cycles between request accept and response (0..15).
REQ-003 SHALL have parameter NOP_WORD, default 32'h00000013, word returned on any error response.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 read_enable_cpu  input  1  fetch request strobe from the fetch stage.
REQ-007 pc_rom  input  32  byte address of requested instruction.
REQ-008 flush  input  1  abort any in-flight fetch (branch redirect).
REQ-009 load_en  input  1  program-load write strobe.
REQ-010 load_addr  input  32  byte address for program-load write.
REQ-011 load_data  input  32  program-load write data.
REQ-012 req_ready  output  1  request accepted this cycle when high together with read_enable_cpu.
REQ-013 inst  output  32  fetched instruction word.
REQ-014 inst_valid  output  1  inst holds a response this cycle (one-cycle pulse per request).
REQ-015 addr_err  output  1  qualifies inst_valid; request was misaligned or out of range.
REQ-016 busy  output  1  high when state is not IDLE.

Function
REQ-017 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-018 req_ready SHALL be high in IDLE and RESP, low in WAIT.
REQ-019 Accept (read_enable_cpu && req_ready && !flush) SHALL latch pc_rom and load wait counter with WAIT_STATES.
REQ-020 On accept, next state SHALL be WAIT if WAIT_STATES>0, else RESP.
REQ-021 In WAIT, counter SHALL decrement each cycle; at counter==1 next state SHALL be RESP.
REQ-022 On the edge entering RESP, inst SHALL be registered from array[word index] (pc[log2(DEPTH_WORDS)+1:2]); response latency = WAIT_STATES+1 cycles after accept.
REQ-023 inst_valid SHALL be high exactly the cycles spent in RESP.
REQ-024 From RESP, next state SHALL be WAIT/RESP on a new accept (back-to-back), else IDLE; full throughput of one word per cycle when WAIT_STATES=0.
REQ-025 pc[1:0]!=0 or pc[31:2]>=DEPTH_WORDS SHALL produce inst=NOP_WORD and addr_err=1 with normal latency.
REQ-026 addr_err SHALL be 0 whenever inst_valid is 0.
REQ-027 flush SHALL force next state IDLE, suppress any response due next cycle, and block acceptance that cycle.
REQ-028 load_en SHALL write load_data to array[load_addr[..:2]] at the edge; out-of-range or misaligned loads SHALL be ignored.
REQ-029 Load and response read of the same word on the same edge SHALL return the pre-write data.
REQ-030 inst SHALL hold its last value outside RESP.
REQ-031 Array contents SHALL be undefined after configuration and unaffected by reset.

Reset
REQ-032 reset SHALL dominate flush, load_en and requests.
REQ-033 On reset: state=IDLE, counter=0, inst=0, inst_valid=0, addr_err=0, busy=0, req_ready=1 the following cycle.
REQ-034 reset asserted mid-WAIT SHALL discard the pending fetch; no inst_valid after reset release until a new accept.

Verification
REQ-035 Load word 0x4 = 0x00500093, WAIT_STATES=2, request pc=0x4 at cycle 0 -> inst_valid=1 at cycle 3, inst=0x00500093, addr_err=0, req_ready low cycles 1-2.
REQ-036 WAIT_STATES=0, requests pc=0x0,0x4,0x8 on consecutive cycles -> three consecutive inst_valid pulses, words in order, req_ready never low.
REQ-037 Request pc=0x6, then pc=DEPTH_WORDS*4 -> two responses inst=0x00000013, addr_err=1.
REQ-038 WAIT_STATES=2, flush one cycle after accept -> no inst_valid, state IDLE, next request served normally.
REQ-039 reset during WAIT -> all outputs at reset values, no stale inst_valid; same-edge load/read of word 0x8 -> old value returned, new value on next fetch.
